// File: rtl/layer_sequencer_pkg.sv
// Shared types and default sizing for the fully-connected layer sequencer.
package layer_sequencer_pkg;

  localparam int NU_COUNT     = 8;                     // default MAC lanes per tile
  localparam int Q_SIZE       = $clog2(NU_COUNT) + 1;  // width needed to hold a lane count
  localparam int XY_MEM_DEPTH = 1 << 10;               // default xy memory words
  localparam int W_MEM_DEPTH  = 1 << 10;               // default weight memory words

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_UPD,
    S_SERIAL,
    S_FLUSH,
    S_NEXT
  } seq_state_t;

endpackage

// File: rtl/layer_sequencer_delay.sv
// Write-strobe/address delay line that aligns result writes with the
// activation function output, DEPTH cycles after the element is presented.
module seq_delay_line #(
  parameter int DEPTH = 1,
  parameter int AW    = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  output logic          o_we,
  output logic [AW-1:0] o_addr
);

  logic [DEPTH-1:0] r_we;
  logic [AW-1:0]    r_addr [DEPTH];

  // Shift {we, addr} one stage per cycle; cleared on reset so no stale write escapes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we <= '0;
      for (int i = 0; i < DEPTH; i++) r_addr[i] <= '0;
    end else begin
      r_we[0]   <= i_we;
      r_addr[0] <= i_addr;
      for (int i = 1; i < DEPTH; i++) begin
        r_we[i]   <= r_we[i-1];
        r_addr[i] <= r_addr[i-1];
      end
    end
  end

  assign o_we   = r_we[DEPTH-1];
  assign o_addr = r_addr[DEPTH-1];

endmodule

// File: rtl/layer_sequencer.sv
// Sequences one fully-connected layer: tiles neurons into groups of NU_COUNT,
// streams operands, accumulates, serializes, activates and writes results back.
module layer_sequencer #(
  parameter int NU_COUNT = layer_sequencer_pkg::NU_COUNT,
  parameter int XY_AW    = 10,
  parameter int W_AW     = 10,
  parameter int LEN_W    = 10,
  parameter int ACT_LAT  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [XY_AW-1:0]    in_base,
  input  logic [LEN_W-1:0]    in_len,
  input  logic [XY_AW-1:0]    out_base,
  input  logic [LEN_W-1:0]    out_len,
  input  logic [W_AW-1:0]     w_base,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [XY_AW-1:0]    xy_read_addr,
  output logic [W_AW-1:0]     w_read_addr,
  output logic [NU_COUNT-1:0] mac_reg_enable,
  output logic                mac_acc_loopback,
  output logic                mac_acc_update,
  output logic                serializer_update,
  output logic                serializer_shift,
  output logic                act_input_select,
  output logic                xy_write_enable,
  output logic [XY_AW-1:0]    xy_write_addr
);

  import layer_sequencer_pkg::*;

  localparam logic [LEN_W-1:0] NU_L   = LEN_W'(NU_COUNT);
  localparam logic [LEN_W-1:0] ACT_M1 = LEN_W'(ACT_LAT - 1);

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic [XY_AW-1:0] r_in_base;
  logic [XY_AW-1:0] r_out_base;
  logic [LEN_W-1:0] r_in_len;
  logic [LEN_W-1:0] r_rem;       // neurons not yet retired, including the current tile
  logic [LEN_W-1:0] r_tile_off;  // first neuron index of the current tile
  logic [LEN_W-1:0] r_cnt;       // cycle index within the current state
  logic [W_AW-1:0]  r_w_ptr;     // runs across tiles; only reloaded by a new descriptor
  logic             r_err;

  logic [LEN_W-1:0] w_k;
  logic             w_last_tile;
  logic             w_zero;
  logic             w_accept;
  logic             w_lanes_on;
  logic             w_dl_we;
  logic [XY_AW-1:0] w_dl_addr;

  assign w_k         = (r_rem > NU_L) ? NU_L : r_rem;
  assign w_last_tile = (r_rem == w_k);
  assign w_zero      = (in_len == '0) || (out_len == '0);
  assign w_accept    = start && (r_state == S_IDLE) && !r_err;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: each phase ends on its own cycle count.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept && !w_zero) w_next = S_MAC;
      S_MAC:    if (r_cnt == r_in_len - 1'b1) w_next = S_DRAIN;
      S_DRAIN:  w_next = S_UPD;
      S_UPD:    w_next = S_SERIAL;
      S_SERIAL: if (r_cnt == w_k - 1'b1) w_next = S_FLUSH;
      S_FLUSH:  if (r_cnt == ACT_M1) w_next = S_NEXT;
      S_NEXT:   w_next = w_last_tile ? S_IDLE : S_MAC;
      default:  w_next = S_IDLE;
    endcase
  end

  // Descriptor capture, per-state cycle counter, tile bookkeeping and weight pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_base  <= '0;
      r_out_base <= '0;
      r_in_len   <= '0;
      r_rem      <= '0;
      r_tile_off <= '0;
      r_cnt      <= '0;
      r_w_ptr    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_accept && w_zero;
      if (r_state == S_IDLE || w_next != r_state) r_cnt <= '0;
      else                                         r_cnt <= r_cnt + 1'b1;
      if (w_accept) begin
        r_in_base  <= in_base;
        r_out_base <= out_base;
        r_in_len   <= in_len;
        r_rem      <= out_len;
        r_tile_off <= '0;
        r_w_ptr    <= w_base;
      end
      if (r_state == S_MAC) r_w_ptr <= r_w_ptr + 1'b1;
      if (r_state == S_NEXT) begin
        r_tile_off <= r_tile_off + w_k;
        r_rem      <= r_rem - w_k;
      end
    end
  end

  // Datapath control decode from the current state and cycle index.
  always_comb begin
    busy              = (r_state != S_IDLE) || r_err;
    done              = ((r_state == S_NEXT) && w_last_tile) || r_err;
    err               = r_err;
    xy_read_addr      = '0;
    w_read_addr       = '0;
    mac_acc_update    = 1'b0;
    mac_acc_loopback  = 1'b0;
    serializer_update = (r_state == S_UPD);
    serializer_shift  = 1'b0;
    act_input_select  = 1'b0;
    w_lanes_on        = (r_state == S_MAC) || (r_state == S_DRAIN);
    w_dl_we           = 1'b0;
    w_dl_addr         = r_out_base + XY_AW'(r_tile_off) + XY_AW'(r_cnt);
    for (int j = 0; j < NU_COUNT; j++) begin
      mac_reg_enable[j] = w_lanes_on && (LEN_W'(j) < w_k);
    end
    case (r_state)
      S_MAC: begin
        xy_read_addr     = r_in_base + XY_AW'(r_cnt);
        w_read_addr      = r_w_ptr;
        mac_acc_update   = (r_cnt != '0);
        mac_acc_loopback = (r_cnt > LEN_W'(1));
      end
      S_DRAIN: begin
        mac_acc_update   = 1'b1;
        mac_acc_loopback = (r_in_len > LEN_W'(1));
      end
      S_SERIAL: begin
        act_input_select = 1'b1;
        serializer_shift = (r_cnt != w_k - 1'b1);
        w_dl_we          = 1'b1;
      end
      default: ;
    endcase
  end

  seq_delay_line #(
    .DEPTH(ACT_LAT),
    .AW   (XY_AW)
  ) u_delay (
    .i_clk  (clk),
    .i_rst_n(reset),
    .i_we   (w_dl_we),
    .i_addr (w_dl_addr),
    .o_we   (xy_write_enable),
    .o_addr (xy_write_addr)
  );

endmodule
